// File: rtl/jtopl_wr_ctl.sv
// jtopl_wr_ctl: CPU write controller for the OPL register file.
// Latches address/data bus cycles, decodes the register address into one up_*
// strobe plus sel_group/sel_sub/dout, and holds them for HOLD_CEN cen ticks so
// every slot of the shifting CSR sees the value. Owns globals 0x01 and 0xBD.
// Ports: clk, rst_n (async, active low), cen (slot tick), cs_n/wr_n/addr/din (CPU bus);
// busy, ovf, write, dout, sel_group, sel_sub, up_* strobes, wave_mode, am_dep,
// vib_dep, rhy_en, rhy_kon.
module jtopl_wr_ctl #(
    parameter int HOLD_CEN = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       ovf,
    output logic       write,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       wave_mode,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       rhy_en,
    output logic [4:0] rhy_kon
);
    localparam int CW = $clog2(HOLD_CEN + 1);
    typedef enum logic {IDLE, APPLY} st_t;
    st_t           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          act_q, act_d, wrp_q, wrp_d, pv_q, pv_d, wr_q, wm_q, wm_d, ovf_q, ovf_d;
    // update word layout: {type[2:0], group[1:0], sub[2:0], data[7:0]}
    logic [15:0]   cur_q, cur_d, pnd_q, pnd_d, new_w;
    logic [7:0]    alat_q, alat_d, bd_q, bd_d, ups;
    logic          wr_req, wr_edge, ad_wr, dt_wr, new_v, is_op, is_ch;
    logic [2:0]    op_ty, ch_ty, ch_s;
    logic [1:0]    ch_g;

    assign wr_req  = ~cs_n & ~wr_n;
    assign wr_edge = wr_req & ~wr_q;
    assign ad_wr   = wr_edge & ~addr;
    assign dt_wr   = wr_edge & addr;

    // address decode; type index selects the up_* strobe (0=mult .. 7=fbcon)
    always_comb begin
        is_op = (alat_q[7:5] inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7}) && alat_q[4:3] != 2'd3 && alat_q[2:0] <= 3'd5;
        is_ch = (alat_q[7:4] inside {4'hA, 4'hB, 4'hC}) && alat_q[3:0] <= 4'd8;
        op_ty = alat_q[7:5] == 3'd7 ? 3'd4 : alat_q[7:5] - 3'd1;
        ch_ty = alat_q[7:4] == 4'hA ? 3'd5 : alat_q[7:4] == 4'hB ? 3'd6 : 3'd7;
        ch_g  = alat_q[3:0] >= 4'd6 ? 2'd2 : alat_q[3:0] >= 4'd3 ? 2'd1 : 2'd0;
        // low 3 bits suffice: 6,7,8 wrap to 6,7,0 and subtracting 6 mod 8 gives n%3
        ch_s  = alat_q[3:0] >= 4'd6 ? alat_q[2:0] - 3'd6 : alat_q[3:0] >= 4'd3 ? alat_q[2:0] - 3'd3 : alat_q[2:0];
        new_w = is_op ? {op_ty, alat_q[4:3], alat_q[2:0], din} : {ch_ty, ch_g, ch_s, din};
        new_v = dt_wr && (is_op || is_ch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            wrp_q  <= 1'b0;
            pv_q   <= 1'b0;
            wr_q   <= 1'b0;
            wm_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cur_q  <= '0;
            pnd_q  <= '0;
            alat_q <= '0;
            bd_q   <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            wrp_q  <= wrp_d;
            pv_q   <= pv_d;
            wr_q   <= wr_req;
            wm_q   <= wm_d;
            ovf_q  <= ovf_d;
            cur_q  <= cur_d;
            pnd_q  <= pnd_d;
            alat_q <= alat_d;
            bd_q   <= bd_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        wrp_d  = 1'b0;
        pv_d   = pv_q;
        wm_d   = wm_q;
        ovf_d  = ovf_q;
        cur_d  = cur_q;
        pnd_d  = pnd_q;
        alat_d = ad_wr ? din : alat_q;
        bd_d   = dt_wr && alat_q == 8'hBD ? din : bd_q;
        if (dt_wr && alat_q == 8'h01) begin
            wm_d  = din[5];
            ovf_d = 1'b0;
        end
        if (st_q == IDLE) begin
            if (new_v) begin
                {st_d, act_d, wrp_d, cnt_d, cur_d} = {APPLY, 1'b1, 1'b1, CW'(HOLD_CEN), new_w};
            end
        end else if (cnt_q == '0) begin
            // gap clock after expiry: start the pending update, a fresh write, or finish
            if (pv_q) begin
                {act_d, wrp_d, cnt_d, cur_d} = {1'b1, 1'b1, CW'(HOLD_CEN), pnd_q};
                pv_d  = new_v;
                pnd_d = new_v ? new_w : pnd_q;
            end else if (new_v) begin
                {act_d, wrp_d, cnt_d, cur_d} = {1'b1, 1'b1, CW'(HOLD_CEN), new_w};
            end else begin
                st_d = IDLE;
            end
        end else begin
            if (cen) begin
                cnt_d = cnt_q - CW'(1);
                act_d = cnt_q != CW'(1);
            end
            if (new_v) begin
                if (pv_q) begin
                    ovf_d = 1'b1;
                end else begin
                    pv_d  = 1'b1;
                    pnd_d = new_w;
                end
            end
        end
    end

    always_comb begin
        ups       = act_q ? 8'd1 << cur_q[15:13] : 8'd0;
        busy      = st_q == APPLY;
        ovf       = ovf_q;
        write     = wrp_q;
        dout      = cur_q[7:0];
        sel_sub   = cur_q[10:8];
        sel_group = cur_q[12:11];
        {up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = ups;
        wave_mode = wm_q;
        {am_dep, vib_dep, rhy_en, rhy_kon} = bd_q;
    end
endmodule

// File: tb/tb_jtopl_wr_ctl.sv
// tb_jtopl_wr_ctl: directed self-checking bench for jtopl_wr_ctl.
module tb_jtopl_wr_ctl;
    logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0, cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
    logic [7:0] din = 8'd0;
    logic       busy, ovf, write, wave_mode, am_dep, vib_dep, rhy_en;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon;
    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [4:0] rhy_kon;
    logic [7:0] ups;
    int errs = 0, checks = 0, hi = 0, ph = 0, base = 0, n = 0;

    jtopl_wr_ctl #(.HOLD_CEN(24)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .busy(busy), .ovf(ovf), .write(write), .dout(dout), .sel_group(sel_group), .sel_sub(sel_sub),
        .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
        .up_wav(up_wav), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
        .wave_mode(wave_mode), .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en), .rhy_kon(rhy_kon)
    );

    assign ups = {up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

    always #5 clk = ~clk;

    // cen high for one clock in three, changed well away from the edges
    always @(posedge clk) begin
        #2;
        ph  = ph == 2 ? 0 : ph + 1;
        cen = ph == 0;
    end

    // counts cen ticks consumed while any strobe is held
    always @(posedge clk) if ((|ups) && cen) hi = hi + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        bus_wr(1'b0, a);
        bus_wr(1'b1, d);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_write(input string tag);
        int g = 0;
        while (!write && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk(tag, write, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {write, ovf, wave_mode, dout, sel_group, sel_sub, ups, am_dep, vib_dep, rhy_en, rhy_kon}, 0);
        rst_n = 1'b1;

        // operator write 0x43 -> ksl_tl, group 0, sub 3, held 24 cen
        base = hi;
        reg_wr(8'h43, 8'h3F);
        chk("op_write", write, 1);
        chk("op_strobe", ups, 8'b0000_0010);
        chk("op_sel", {sel_group, sel_sub}, {2'd0, 3'd3});
        chk("op_dout", dout, 8'h3F);
        chk("op_busy", busy, 1);
        @(negedge clk);
        chk("op_write_1clk", write, 0);
        wait_idle("op_idle");
        chk("op_hold", hi - base, 24);
        chk("op_clear", ups, 0);

        // channel write 0xB7 -> fnumhi, group 2, sub 1
        reg_wr(8'hB7, 8'h2A);
        chk("ch_strobe", ups, 8'b0100_0000);
        chk("ch_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
        chk("ch_dout", dout, 8'h2A);
        wait_idle("ch_idle");

        // invalid addresses are ignored
        reg_wr(8'h26, 8'h55);
        chk("inv26", {busy, write, ups}, 0);
        reg_wr(8'hC9, 8'h55);
        chk("invC9", {busy, write, ups}, 0);

        // pending buffer: second applied after first, third dropped
        base = hi;
        reg_wr(8'h20, 8'h01);
        chk("p1_strobe", {ups, sel_sub, dout}, {8'b0000_0001, 3'd0, 8'h01});
        reg_wr(8'h21, 8'h02);
        chk("p2_ovf", ovf, 0);
        reg_wr(8'h22, 8'h03);
        chk("p3_ovf", ovf, 1);
        chk("p3_still_first", {ups, sel_sub, dout}, {8'b0000_0001, 3'd0, 8'h01});
        @(negedge clk);
        wait_write("p2_write");
        chk("p2_apply", {ups, sel_group, sel_sub, dout}, {8'b0000_0001, 2'd0, 3'd1, 8'h02});
        wait_idle("p2_idle");
        chk("p_hold", hi - base, 48);
        repeat (4) @(negedge clk);
        chk("p3_dropped", busy, 0);
        reg_wr(8'h01, 8'h20);
        chk("wm_set", wave_mode, 1);
        chk("ovf_clr", ovf, 0);

        // global 0xBD during APPLY: immediate, countdown unaffected
        base = hi;
        reg_wr(8'h60, 8'h55);
        reg_wr(8'hBD, 8'hFF);
        chk("bd_regs", {am_dep, vib_dep, rhy_en, rhy_kon}, 8'hFF);
        chk("bd_inflight", {busy, ups, dout}, {1'b1, 8'b0000_0100, 8'h55});
        wait_idle("bd_idle");
        chk("bd_hold", hi - base, 24);

        // data write on the exact expiry clock goes to pending
        base = hi;
        reg_wr(8'h40, 8'h11);
        bus_wr(1'b0, 8'h83);
        n = 0;
        while (!((hi - base) == 23 && cen) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("exp_found", n < 300, 1);
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h77;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        chk("exp_cleared", {ups, ovf}, 0);
        wait_write("exp_write");
        chk("exp_apply", {ups, sel_group, sel_sub, dout, ovf}, {8'b0000_1000, 2'd0, 3'd3, 8'h77, 1'b0});
        wait_idle("exp_idle");
        chk("exp_hold", hi - base, 48);

        // async reset mid-APPLY with pending full
        reg_wr(8'h20, 8'h01);
        reg_wr(8'h21, 8'h02);
        reg_wr(8'h22, 8'h03);
        chk("ra_pre", {busy, ovf, wave_mode, rhy_kon}, {1'b1, 1'b1, 1'b1, 5'h1F});
        #1 rst_n = 1'b0;
        #1;
        chk("ra_busy", busy, 0);
        chk("ra_outs", {ups, ovf, wave_mode, am_dep, vib_dep, rhy_en, rhy_kon, write}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("ra_pend_gone", {busy, ups}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
